// File: rtl/control_multiciclo_pkg.sv
//------------------------------------------------------------------------------
// control_multiciclo_pkg
//   Shared opcodes, state codes, mux encodings and control-word type for the
//   multicycle MIPS sequencer, ALU control and Control_Unidad.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package control_multiciclo_pkg;

  localparam int NBITS_OP = 6;
  localparam int NBITS_ST = 4;

  localparam logic [NBITS_OP-1:0] OP_BAS  = 6'b000000;
  localparam logic [NBITS_OP-1:0] OP_LW   = 6'b100011;
  localparam logic [NBITS_OP-1:0] OP_SW   = 6'b101011;
  localparam logic [NBITS_OP-1:0] OP_BEQ  = 6'b000100;
  localparam logic [NBITS_OP-1:0] OP_J    = 6'b000010;
  localparam logic [NBITS_OP-1:0] OP_ADDI = 6'b001000;
  localparam logic [NBITS_OP-1:0] OP_HALT = 6'b111111;

  typedef enum logic [NBITS_ST-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_t;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic       halted;
  } ctrl_t;

  function automatic logic op_supported(input logic [NBITS_OP-1:0] op);
    return op inside {OP_BAS, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT};
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_multiciclo_if.sv
//------------------------------------------------------------------------------
// control_multiciclo_if
//   Step gate, opcode and memory handshake in; datapath strobes and status out.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface control_multiciclo_if;
  import control_multiciclo_pkg::*;

  logic                i_Enable;
  logic [NBITS_OP-1:0] i_Opcode;
  logic                i_MemReady;
  logic                o_PCWrite;
  logic                o_PCWriteCond;
  logic                o_IorD;
  logic                o_MemRead;
  logic                o_MemWrite;
  logic                o_IRWrite;
  logic                o_MemToReg;
  logic                o_RegDst;
  logic                o_RegWrite;
  logic                o_ALUSrcA;
  logic [1:0]          o_ALUSrcB;
  logic [1:0]          o_ALUOp;
  logic [1:0]          o_PCSource;
  logic [NBITS_ST-1:0] o_State;
  logic                o_InstrDone;
  logic                o_Illegal;
  logic                o_Halted;

  modport master (
    output i_Enable, i_Opcode, i_MemReady,
    input  o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite, o_IRWrite,
           o_MemToReg, o_RegDst, o_RegWrite, o_ALUSrcA, o_ALUSrcB, o_ALUOp,
           o_PCSource, o_State, o_InstrDone, o_Illegal, o_Halted
  );

  modport slave (
    input  i_Enable, i_Opcode, i_MemReady,
    output o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite, o_IRWrite,
           o_MemToReg, o_RegDst, o_RegWrite, o_ALUSrcA, o_ALUSrcB, o_ALUOp,
           o_PCSource, o_State, o_InstrDone, o_Illegal, o_Halted
  );
endinterface

`default_nettype wire

// File: rtl/control_multiciclo_salidas.sv
//------------------------------------------------------------------------------
// control_multiciclo_salidas
//   Combinational state -> control-word decoder (ungated strobes).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_multiciclo_salidas
  import control_multiciclo_pkg::*;
(
  input  state_t              i_state,
  input  logic [NBITS_OP-1:0] i_opcode,
  input  logic                i_mem_ready,
  output ctrl_t               o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMMSH;
        o_ctrl.illegal   = ~op_supported(i_opcode);
      end
      ST_MEMADR, ST_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      ST_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      ST_ADDIWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      ST_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      ST_HALT: o_ctrl.halted = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_multiciclo.sv
//------------------------------------------------------------------------------
// control_multiciclo
//   Multicycle MIPS sequencer: state register, next-state logic, step gating.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_multiciclo
  import control_multiciclo_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  control_multiciclo_if.slave  bus
);

  state_t r_state;
  ctrl_t  w_raw;
  ctrl_t  w_ctrl;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_FETCH;
    end else if (bus.i_Enable) begin
      case (r_state)
        ST_FETCH:  if (bus.i_MemReady) r_state <= ST_DECODE;
        ST_DECODE: begin
          case (bus.i_Opcode)
            OP_LW, OP_SW: r_state <= ST_MEMADR;
            OP_BAS:       r_state <= ST_EXEC;
            OP_BEQ:       r_state <= ST_BRANCH;
            OP_J:         r_state <= ST_JUMP;
            OP_ADDI:      r_state <= ST_ADDIEX;
            OP_HALT:      r_state <= ST_HALT;
            default:      r_state <= ST_FETCH;
          endcase
        end
        ST_MEMADR: r_state <= (bus.i_Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
        ST_MEMRD:  if (bus.i_MemReady) r_state <= ST_MEMWB;
        ST_MEMWR:  if (bus.i_MemReady) r_state <= ST_FETCH;
        ST_EXEC:   r_state <= ST_ALUWB;
        ST_ADDIEX: r_state <= ST_ADDIWB;
        ST_HALT:   r_state <= ST_HALT;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  control_multiciclo_salidas u_salidas (
    .i_state     (r_state),
    .i_opcode    (bus.i_Opcode),
    .i_mem_ready (bus.i_MemReady),
    .o_ctrl      (w_raw)
  );

  // A frozen step keeps mux selects stable but suppresses every side effect.
  always_comb begin
    w_ctrl = w_raw;
    if (!bus.i_Enable) begin
      w_ctrl.pc_write      = 1'b0;
      w_ctrl.pc_write_cond = 1'b0;
      w_ctrl.ir_write      = 1'b0;
      w_ctrl.reg_write     = 1'b0;
      w_ctrl.mem_write     = 1'b0;
      w_ctrl.mem_read      = 1'b0;
      w_ctrl.instr_done    = 1'b0;
      w_ctrl.illegal       = 1'b0;
    end
    if (i_reset) w_ctrl = '0;
  end

  assign bus.o_PCWrite     = w_ctrl.pc_write;
  assign bus.o_PCWriteCond = w_ctrl.pc_write_cond;
  assign bus.o_IorD        = w_ctrl.iord;
  assign bus.o_MemRead     = w_ctrl.mem_read;
  assign bus.o_MemWrite    = w_ctrl.mem_write;
  assign bus.o_IRWrite     = w_ctrl.ir_write;
  assign bus.o_MemToReg    = w_ctrl.mem_to_reg;
  assign bus.o_RegDst      = w_ctrl.reg_dst;
  assign bus.o_RegWrite    = w_ctrl.reg_write;
  assign bus.o_ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.o_ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.o_ALUOp       = w_ctrl.alu_op;
  assign bus.o_PCSource    = w_ctrl.pc_source;
  assign bus.o_InstrDone   = w_ctrl.instr_done;
  assign bus.o_Illegal     = w_ctrl.illegal;
  assign bus.o_Halted      = w_ctrl.halted;
  assign bus.o_State       = i_reset ? {NBITS_ST{1'b0}} : NBITS_ST'(r_state);

endmodule

`default_nettype wire
